seq_key_lock_unit: RTL and testbench

Parametrised, clocked successor to the benchmark key-gate locking scheme. It loads a locking key serially, checks it against a popcount checksum, then commits it to an active key register. The active key drives two things: a registered XOR key-gate layer on a DATA_W-bit datapath, and LUT_N key-programmed MUX4 LUTs. It sits between the key-delivery port and the locked netlist's primary inputs and LUT sites, so that wrong or partial keys never reach the logic.

---
 rtl/seq_key_lock_unit.sv | 142 ++++++++++++++
 tb/tb_seq_key_lock_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_key_lock_unit.sv
// Serial key loader with popcount checksum, committing to an active key that
// drives a registered XOR key-gate layer and LUT_N key-programmed MUX4 LUTs.
module seq_key_lock_unit #(
    parameter int DATA_W = 8,
    parameter int LUT_N  = 2,
    parameter int CHK_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_start,
    input  logic                 key_valid,
    input  logic                 key_bit,
    output logic                 key_ready,
    output logic                 armed,
    output logic                 key_err,
    input  logic [DATA_W-1:0]    din,
    input  logic                 din_valid,
    output logic [DATA_W-1:0]    dout,
    output logic                 dout_valid,
    input  logic [2*LUT_N-1:0]   lut_sel,
    output logic [LUT_N-1:0]     lut_out
);

    localparam int KEY_W  = DATA_W + 4 * LUT_N;
    localparam int BEATS  = KEY_W + CHK_W;
    localparam int CNT_W  = $clog2(BEATS + 1);
    localparam int KIDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam int CIDX_W = (CHK_W > 1) ? $clog2(CHK_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ARMED,
        ERROR
    } state_t;

    state_t             state;
    logic [KEY_W-1:0]   shadow;
    logic [KEY_W-1:0]   active;
    logic [CHK_W-1:0]   rx_chk;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   chk_idx;
    logic [LUT_N-1:0]   lut_next;

    // Popcount at full width, then truncated to the checksum width.
    function automatic logic [CHK_W-1:0] popcount(input logic [KEY_W-1:0] v);
        int sum;
        sum = 0;
        for (int i = 0; i < KEY_W; i++) sum += int'(v[i]);
        return CHK_W'(sum);
    endfunction

    assign chk_idx = cnt - CNT_W'(KEY_W);

    // NOTE: every FSM register uses <= so all of them update from the same
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            active    <= '0;
            rx_chk    <= '0;
            cnt       <= '0;
            armed     <= 1'b0;
            key_err   <= 1'b0;
            key_ready <= 1'b1;
        end else begin
            case (state)
                IDLE, ARMED, ERROR: begin
                    if (key_start) begin
                        state     <= LOAD;
                        shadow    <= '0;
                        rx_chk    <= '0;
                        cnt       <= '0;
                        key_err   <= 1'b0;
                        key_ready <= 1'b0;
                    end
                end
                LOAD: begin
                    // A restart wins over a coincident beat, which is dropped.
                    if (key_start) begin
                        shadow <= '0;
                        rx_chk <= '0;
                        cnt    <= '0;
                    end else if (key_valid) begin
                        if (cnt < CNT_W'(KEY_W))
                            shadow[cnt[KIDX_W-1:0]] <= key_bit;
                        else
                            rx_chk[chk_idx[CIDX_W-1:0]] <= key_bit;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(BEATS - 1))
                            state <= CHECK;
                    end
                end
                CHECK: begin
                    key_ready <= 1'b1;
                    if (popcount(shadow) == rx_chk) begin
                        active <= shadow;
                        armed  <= 1'b1;
                        state  <= ARMED;
                    end else begin
                        active  <= '0;
                        armed   <= 1'b0;
                        key_err <= 1'b1;
                        state   <= ERROR;
                    end
                end
                default: begin
                    state     <= IDLE;
                    key_ready <= 1'b1;
                end
            endcase
        end
    end

    // Each LUT is a MUX4 over its own nibble of the active key.
    for (genvar g = 0; g < LUT_N; g++) begin : g_lut
        logic [3:0] lut_cfg;
        logic [1:0] sel;
        assign lut_cfg     = active[DATA_W + 4*g +: 4];
        assign sel         = lut_sel[2*g +: 2];
        assign lut_next[g] = lut_cfg[sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            lut_out    <= '0;
        end else if (armed) begin
            dout       <= din ^ active[DATA_W-1:0];
            dout_valid <= din_valid;
            lut_out    <= lut_next;
        end else begin
            dout       <= '0;
            dout_valid <= 1'b0;
            lut_out    <= '0;
        end
    end

endmodule

// File: tb/tb_seq_key_lock_unit.sv
// Directed bench for seq_key_lock_unit: table-driven datapath/LUT vectors
// plus hand-written load, error, reset, re-key and restart sequences.
module tb_seq_key_lock_unit;

    localparam int DATA_W = 8;
    localparam int LUT_N  = 2;
    localparam int CHK_W  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                key_start;
    logic                key_valid;
    logic                key_bit;
    logic                key_ready;
    logic                armed;
    logic                key_err;
    logic [DATA_W-1:0]   din;
    logic                din_valid;
    logic [DATA_W-1:0]   dout;
    logic                dout_valid;
    logic [2*LUT_N-1:0]  lut_sel;
    logic [LUT_N-1:0]    lut_out;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] din;
        logic       din_valid;
        logic [3:0] lut_sel;
        logic [7:0] exp_dout;
        logic       exp_dv;
        logic [1:0] exp_lut;
    } vec_t;

    vec_t vecs[5];

    seq_key_lock_unit #(.DATA_W(DATA_W), .LUT_N(LUT_N), .CHK_W(CHK_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_start  (key_start),
        .key_valid  (key_valid),
        .key_bit    (key_bit),
        .key_ready  (key_ready),
        .armed      (armed),
        .key_err    (key_err),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .lut_sel    (lut_sel),
        .lut_out    (lut_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            key_valid = 1'b1;
            key_bit   = v[i];
            tick();
            key_valid = 1'b0;
            if (i < n - 1) repeat (gap) tick();
        end
    endtask

    // Returns just after the last beat's edge, i.e. with the FSM in CHECK.
    task automatic load_key(input logic [15:0] key, input logic [7:0] chk, input int gap);
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        send_bits({16'h0, key}, 16, gap);
        repeat (gap) tick();
        send_bits({24'h0, chk}, 8, gap);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 5; i++) begin
            din       = vecs[i].din;
            din_valid = vecs[i].din_valid;
            lut_sel   = vecs[i].lut_sel;
            tick();
            check({tag, "_dout"}, dout, vecs[i].exp_dout);
            check({tag, "_dv"},   dout_valid, vecs[i].exp_dv);
            check({tag, "_lut"},  lut_out, vecs[i].exp_lut);
        end
    endtask

    initial begin
        logic [23:0] rekey;

        // Active key 0x86A5: LUT0 nibble 0x6, LUT1 nibble 0x8.
        vecs[0] = '{8'h3C, 1'b1, 4'b1101, 8'h99, 1'b1, 2'b11};
        vecs[1] = '{8'h00, 1'b0, 4'b1011, 8'hA5, 1'b0, 2'b00};
        vecs[2] = '{8'hFF, 1'b1, 4'b0000, 8'h5A, 1'b1, 2'b00};
        vecs[3] = '{8'hA5, 1'b1, 4'b0110, 8'h00, 1'b1, 2'b01};
        vecs[4] = '{8'h5A, 1'b1, 4'b1110, 8'hFF, 1'b1, 2'b11};

        rst = 1'b1; key_start = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
        din = '0; din_valid = 1'b0; lut_sel = '0;
        tick(); tick();
        check("rst_key_ready", key_ready, 1);
        check("rst_armed", armed, 0);
        check("rst_key_err", key_err, 0);
        check("rst_dout", dout, 0);
        check("rst_dv", dout_valid, 0);
        check("rst_lut", lut_out, 0);
        rst = 1'b0;
        tick();

        // Test 1: clean load, CHECK for one cycle, then armed.
        load_key(16'h86A5, 8'h07, 0);
        check("t1_in_check_ready", key_ready, 0);
        check("t1_in_check_armed", armed, 0);
        tick();
        check("t1_armed", armed, 1);
        check("t1_key_err", key_err, 0);
        check("t1_key_ready", key_ready, 1);
        din = 8'h3C; din_valid = 1'b1;
        tick();
        check("t1_dout", dout, 8'h99);
        check("t1_dv", dout_valid, 1);

        // Test 2: table pass, gapped reload of the same key, table again.
        run_table("t2a");
        load_key(16'h86A5, 8'h07, 2);
        check("t2_gap_armed_in_check", armed, 1);
        tick();
        check("t2_gap_armed", armed, 1);
        check("t2_gap_key_err", key_err, 0);
        run_table("t2b");

        // Test 3: bad checksum -> ERROR, outputs gated.
        load_key(16'h86A5, 8'h08, 0);
        tick();
        check("t3_key_err", key_err, 1);
        check("t3_armed", armed, 0);
        check("t3_key_ready", key_ready, 1);
        din = 8'h3C; din_valid = 1'b1; lut_sel = 4'b1101;
        tick();
        check("t3_dout", dout, 0);
        check("t3_dv", dout_valid, 0);
        check("t3_lut", lut_out, 0);

        // Test 4: async reset mid-load from an armed state.
        load_key(16'h86A5, 8'h07, 0);
        tick();
        check("t4_pre_armed", armed, 1);
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        send_bits({16'h0, 16'h86A5}, 10, 0);
        check("t4_pre_dout", dout, 8'h99);
        #4 rst = 1'b1;
        #1;
        check("t4_rst_armed", armed, 0);
        check("t4_rst_dout", dout, 0);
        check("t4_rst_dv", dout_valid, 0);
        check("t4_rst_lut", lut_out, 0);
        check("t4_rst_ready", key_ready, 1);
        #2 rst = 1'b0;
        send_bits({24'h0, 8'hFF}, 14, 0);
        repeat (3) tick();
        check("t4_idle_ready", key_ready, 1);
        check("t4_idle_armed", armed, 0);
        check("t4_idle_key_err", key_err, 0);

        // Test 5: re-key while streaming; old key holds until commit.
        load_key(16'h86A5, 8'h07, 0);
        tick();
        din = 8'hFF; din_valid = 1'b1;
        tick();
        check("t5_pre_dout", dout, 8'h5A);
        rekey = {8'h02, 16'h0011};
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        check("t5_start_dout", dout, 8'h5A);
        for (int i = 0; i < 24; i++) begin
            key_valid = 1'b1;
            key_bit   = rekey[i];
            tick();
            key_valid = 1'b0;
            check("t5_load_dout", dout, 8'h5A);
            check("t5_load_armed", armed, 1);
        end
        tick();
        check("t5_commit_dout", dout, 8'h5A);
        check("t5_commit_armed", armed, 1);
        tick();
        check("t5_new_dout", dout, 8'hEE);
        check("t5_new_armed", armed, 1);

        // Test 6: restart coincident with a beat discards that beat.
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        send_bits(32'h1F, 5, 0);
        key_start = 1'b1; key_valid = 1'b1; key_bit = 1'b1;
        tick();
        key_start = 1'b0; key_valid = 1'b0;
        send_bits({16'h0, 16'h86A5}, 16, 0);
        check("t6_still_loading", key_ready, 0);
        send_bits({24'h0, 8'h07}, 8, 0);
        check("t6_in_check", key_ready, 0);
        tick();
        check("t6_armed", armed, 1);
        check("t6_key_err", key_err, 0);
        din = 8'h3C; din_valid = 1'b1;
        tick();
        check("t6_dout", dout, 8'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
